parking_gate_ctrl: RTL

- Entry-barrier controller and occupancy keeper for the parking lot.
- Consumes the per-lane car detector pulses (car entered / car left) and a driver entry request.
- Decides whether to open the barrier, holds it open for a bounded time, closes it after the car passes, and maintains a saturating occupancy count with full/empty/error indications.
- Sits between the lane sensor state machines and the barrier actuator / display logic.

---
 rtl/parking_gate_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/parking_gate_ctrl.sv
// Entry barrier controller: grants or denies entry, times the barrier open/guard
// windows, and keeps a saturating occupancy count with full/empty/sticky-error flags.
module parking_gate_ctrl #(
  parameter int unsigned CAPACITY     = 10,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned OPEN_CYCLES  = 8,
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned TMR_W        = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             req_in,
  input  logic             car_in,
  input  logic             car_out,
  output logic             gate_open,
  output logic             grant,
  output logic             deny,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] ocupacao,
  output logic             erro
);

  localparam logic [CNT_W-1:0] CAP_V   = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] OPEN_T  = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] GUARD_T = TMR_W'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, OPEN, PASS} state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;

  logic [CNT_W-1:0] occ_next_c;
  logic             ovf_c;
  logic             unf_c;

  // Next occupancy with saturation; simultaneous in/out cancels out.
  always_comb begin
    occ_next_c = ocupacao;
    ovf_c      = 1'b0;
    unf_c      = 1'b0;
    if (car_in && !car_out) begin
      if (ocupacao == CAP_V) ovf_c = 1'b1;
      else                   occ_next_c = ocupacao + CNT_W'(1);
    end else if (car_out && !car_in) begin
      if (ocupacao == '0) unf_c = 1'b1;
      else                occ_next_c = ocupacao - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state     <= IDLE;
      timer     <= '0;
      ocupacao  <= '0;
      gate_open <= 1'b0;
      grant     <= 1'b0;
      deny      <= 1'b0;
      erro      <= 1'b0;
      full      <= 1'b0;
      empty     <= 1'b1;
    end else begin
      grant    <= 1'b0;
      deny     <= 1'b0;
      ocupacao <= occ_next_c;
      full     <= (occ_next_c == CAP_V);
      empty    <= (occ_next_c == '0);

      // A car entering outside the authorized window is tailgating.
      if (ovf_c || unf_c || (car_in && state != OPEN)) erro <= 1'b1;

      case (state)
        IDLE: begin
          if (req_in) begin
            if (full) begin
              deny <= 1'b1;
            end else begin
              state     <= OPEN;
              timer     <= OPEN_T;
              grant     <= 1'b1;
              gate_open <= 1'b1;
            end
          end
        end
        OPEN: begin
          if (car_in) begin
            state <= PASS;
            timer <= GUARD_T;
          end else if (timer == '0) begin
            state     <= IDLE;
            gate_open <= 1'b0;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        PASS: begin
          if (timer == '0) begin
            state     <= IDLE;
            gate_open <= 1'b0;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          gate_open <= 1'b0;
        end
      endcase
    end
  end

endmodule
